// File: rtl/hc05_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hc05_uart_pkg
// Description : Shared constants and deframer state encoding for the HC-05
//               receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package hc05_uart_pkg;

  // 1 MHz system clock divided down to 9600 baud
  localparam int c_clks_per_bit_default = 104;

  // 8N1 frame: start + 8 data + stop
  localparam int c_data_bits  = 8;
  localparam int c_frame_bits = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage : hc05_uart_pkg
`default_nettype wire

// File: rtl/hc05_uart_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Small first-word-fall-through byte FIFO. A push into a full
//               buffer is dropped (and reported) unless a pop happens in the
//               same cycle, in which case both take effect.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          i_push,
  input  logic [7:0]    i_push_data,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic          o_valid,
  output logic [AW:0]   o_count,
  output logic          o_drop
);

  localparam int           c_cw   = AW + 1;
  localparam logic [AW:0]  c_full = c_cw'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_full);
  assign w_do_pop  = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot the incoming byte needs
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_drop    = i_push & w_full & ~w_do_pop;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = ~w_empty;
  assign o_count = r_count;

  // Pointer, occupancy and storage update; pointers wrap modulo DEPTH
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/hc05_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : hc05_uart_rx
// Description : HC-05 receive front end: rxd synchroniser, 8N1 deframer,
//               receive FIFO and sticky framing/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module hc05_uart_rx
  import hc05_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit_default,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               rxd,
  input  logic               rx_enable,
  input  logic               rd_en,
  input  logic               clear_errors,
  output logic [7:0]         data_out,
  output logic               data_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               rx_busy,
  output logic               frame_error,
  output logic               overrun
);

  localparam int                  c_baud_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_baud_w-1:0] c_half_last = c_baud_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_baud_w-1:0] c_bit_last  = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [2:0]          c_last_idx  = 3'(c_data_bits - 1);

  logic [1:0]          r_sync;
  rx_state_t           r_state;
  logic [c_baud_w-1:0] r_baud_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_push;
  logic [7:0]          r_push_data;
  logic                r_frame_error;
  logic                r_overrun;

  logic w_rxd_s;
  logic w_bit_done;
  logic w_frame_evt;
  logic w_fifo_drop;

  assign w_rxd_s    = r_sync[1];
  assign w_bit_done = (r_baud_cnt == c_bit_last);
  // Stop bit sampled low while still armed
  assign w_frame_evt = rx_enable && (r_state == ST_STOP) && w_bit_done && !w_rxd_s;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rxd};
    end
  end

  // Deframer: mid-bit sampling of start, 8 data bits LSB first, and stop
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      if (!rx_enable) begin
        r_state    <= ST_IDLE;
        r_baud_cnt <= '0;
        r_bit_idx  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_rxd_s) begin
              r_state    <= ST_START;
              r_baud_cnt <= '0;
            end
          end
          ST_START: begin
            if (r_baud_cnt == c_half_last) begin
              r_baud_cnt <= '0;
              r_bit_idx  <= '0;
              // A line already back high mid start bit was only a glitch
              r_state    <= w_rxd_s ? ST_IDLE : ST_DATA;
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (w_bit_done) begin
              r_shift[r_bit_idx] <= w_rxd_s;
              r_baud_cnt         <= '0;
              if (r_bit_idx == c_last_idx) begin
                r_state <= ST_STOP;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          ST_STOP: begin
            if (w_bit_done) begin
              r_baud_cnt <= '0;
              if (w_rxd_s) begin
                r_push      <= 1'b1;
                r_push_data <= r_shift;
                r_state     <= ST_IDLE;
              end else begin
                r_state <= ST_BREAK;
              end
            end else begin
              r_baud_cnt <= r_baud_cnt + 1'b1;
            end
          end
          ST_BREAK: begin
            // Wait out a held-low line so it cannot retrigger a start bit
            if (w_rxd_s) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_frame_evt) begin
        r_frame_error <= 1'b1;
      end else if (clear_errors) begin
        r_frame_error <= 1'b0;
      end
      if (w_fifo_drop) begin
        r_overrun <= 1'b1;
      end else if (clear_errors) begin
        r_overrun <= 1'b0;
      end
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock       (clock),
    .resetn      (resetn),
    .i_push      (r_push),
    .i_push_data (r_push_data),
    .i_pop       (rd_en),
    .o_head      (data_out),
    .o_valid     (data_valid),
    .o_count     (fifo_count),
    .o_drop      (w_fifo_drop)
  );

  assign rx_busy     = (r_state != ST_IDLE);
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;

endmodule : hc05_uart_rx
`default_nettype wire

// File: tb/tb_hc05_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hc05_uart_rx
// Description : Self-checking bench for hc05_uart_rx. Drives 8N1 frames on
//               rxd and compares against a queue-based model of the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc05_uart_rx;

  localparam int CPB   = 104;
  localparam int DEPTH = 8;
  // Clocks from the IDLE-to-START edge until the byte is visible at the head
  localparam int PUSH_LAT = CPB / 2 + 9 * CPB + 1;

  logic       clock        = 1'b0;
  logic       resetn       = 1'b0;
  logic       rxd          = 1'b1;
  logic       rx_enable    = 1'b0;
  logic       rd_en        = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic [3:0] fifo_count;
  logic       rx_busy;
  logic       frame_error;
  logic       overrun;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: received bytes in arrival order plus the two flags
  logic [7:0] exp_q[$];
  logic       exp_ovr  = 1'b0;
  logic       exp_ferr = 1'b0;

  always #5 clock = ~clock;

  hc05_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .FIFO_AW      (3)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .rxd          (rxd),
    .rx_enable    (rx_enable),
    .rd_en        (rd_en),
    .clear_errors (clear_errors),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .fifo_count   (fifo_count),
    .rx_busy      (rx_busy),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; holds the level for one bit period
  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clock);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (stop_ok) begin
      drive_bit(1'b1);
    end else begin
      rxd = 1'b0;
      repeat (300) @(negedge clock);
      rxd = 1'b1;
    end
    repeat (20) @(negedge clock);
  endtask

  // A complete, well-framed byte either lands in the buffer or is lost
  task automatic model_rx(input logic [7:0] b);
    if (exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(b);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, fifo_count, exp_q.size());
    check({tag, "_valid"}, data_valid, (exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_head"}, data_out, exp_q[0]);
    check({tag, "_ferr"}, frame_error, exp_ferr);
    check({tag, "_ovr"}, overrun, exp_ovr);
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) return;
    check({tag, "_pop_valid"}, data_valid, 1);
    check({tag, "_pop_data"}, data_out, exp_q[0]);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    @(negedge clock);
    clear_errors = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
  endtask

  // Bounded wait for the deframer to leave IDLE; sampled just after the edge
  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (!rx_busy && k < 300) begin
      @(posedge clock);
      #1;
      k++;
    end
    check({tag, "_start_seen"}, rx_busy, 1);
  endtask

  task automatic watch_first();
    wait_start("first");
    repeat (PUSH_LAT - 1) @(posedge clock);
    #1;
    check("first_not_yet_valid", data_valid, 0);
    @(posedge clock);
    #1;
    check("first_valid_at_989", data_valid, 1);
    check("first_data_at_989", data_out, 8'hA5);
    check("first_count_at_989", fifo_count, 1);
  endtask

  // Raise rd_en so it is seen on exactly the edge that pushes the 9th byte
  task automatic watch_pop();
    wait_start("simul");
    repeat (PUSH_LAT - 1) @(posedge clock);
    @(negedge clock);
    check("simul_count_before", fifo_count, DEPTH);
    check("simul_head_before", data_out, exp_q[0]);
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    void'(exp_q.pop_front());
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: timeout reached, expected finish before 5000000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] partial;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_ovr", overrun, 0);
    @(negedge clock);
    resetn    = 1'b1;
    rx_enable = 1'b1;
    repeat (5) @(negedge clock);

    // First byte with exact latency
    fork
      send_byte(8'hA5, 1'b1);
      watch_first();
    join
    model_rx(8'hA5);
    check("first_busy_after", rx_busy, 0);
    check_state("first");
    pop_check("first");

    // Short low pulse must be rejected at mid start bit
    rxd = 1'b0;
    repeat (10) @(negedge clock);
    check("glitch_busy_during", rx_busy, 1);
    repeat (10) @(negedge clock);
    rxd = 1'b1;
    repeat (80) @(negedge clock);
    check("glitch_busy_after", rx_busy, 0);
    check_state("glitch");

    // Framing error, then recovery
    send_byte(8'h3C, 1'b0);
    exp_ferr = 1'b1;
    check("frame_busy_after", rx_busy, 0);
    check_state("frame");
    send_byte(8'h55, 1'b1);
    model_rx(8'h55);
    check_state("frame_next");
    pop_check("frame_next");
    check("frame_sticky", frame_error, 1);
    pulse_clear();
    check_state("frame_cleared");

    // Overrun: nine bytes, no reads
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_byte(b, 1'b1);
      model_rx(b);
    end
    check_state("ovr_full");
    for (int i = 0; i < DEPTH; i++) pop_check("ovr_drain");
    check_state("ovr_empty");
    pulse_clear();
    check_state("ovr_cleared");

    // Full buffer with a pop in the very cycle of the push
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, 1'b1);
      model_rx(b);
    end
    check_state("simul_fill");
    b = 8'($urandom_range(0, 255));
    fork
      send_byte(b, 1'b1);
      watch_pop();
    join
    model_rx(b);
    check_state("simul_after");
    for (int i = 0; i < DEPTH; i++) pop_check("simul_drain");
    check_state("simul_empty");

    // Disable mid-byte keeps existing contents and drops the partial byte
    b = 8'($urandom_range(0, 255));
    send_byte(b, 1'b1);
    model_rx(b);
    partial = 8'hF0;
    @(negedge clock);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    check("dis_busy_mid", rx_busy, 1);
    rx_enable = 1'b0;
    @(negedge clock);
    check("dis_busy_off", rx_busy, 0);
    for (int i = 4; i < 8; i++) drive_bit(partial[i]);
    drive_bit(1'b1);
    repeat (20) @(negedge clock);
    check_state("dis_hold");
    rx_enable = 1'b1;
    repeat (5) @(negedge clock);
    send_byte(8'h0F, 1'b1);
    model_rx(8'h0F);
    check_state("dis_reenable");
    pop_check("dis_old");
    pop_check("dis_new");

    // Randomised traffic with interleaved reads
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      send_byte(b, 1'b1);
      model_rx(b);
      if ($urandom_range(0, 1) == 1) pop_check("rand");
      check_state("rand");
    end
    while (exp_q.size() != 0) pop_check("rand_drain");
    check_state("rand_empty");

    // Read while empty is ignored
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
    @(negedge clock);
    check_state("empty_read");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hc05_uart_rx
`default_nettype wire
